rv32im_csr_unit: RTL and testbench



---
 rtl/rv32im_csr_unit.sv | 183 ++++++++++++++++++
 tb/tb_rv32im_csr_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rv32im_csr_unit.sv
// Machine-mode CSR file for the RV32IM core: combinational read of the pre-write
// value, Zicsr read-modify-write committed on the next edge, free-running 64-bit cycle counter.
module rv32im_csr_unit (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [11:0] csr_addr_i,
    input  logic [31:0] val_csr_i,
    input  logic        we_csr_i,
    input  logic        re_csr_i,
    input  logic [2:0]  csr_opcode_i,
    output logic [31:0] val_csr_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;

    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
    localparam logic [31:0] MISA_VALUE = 32'h4000_1100;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

    logic        mstatus_mie_q, mstatus_mie_d;
    logic        mstatus_mpie_q, mstatus_mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [31:0] csr_rdata_s;
    logic [31:0] wdata_s;
    logic        op_valid_s;
    logic        wr_en_s;
    logic [63:0] mcycle_inc_s;

    logic sel_mstatus_s, sel_mie_s, sel_mtvec_s, sel_mscratch_s, sel_mepc_s;
    logic sel_mcause_s, sel_mtval_s, sel_mcycle_s, sel_mcycleh_s;
    logic sel_minstret_s, sel_minstreth_s;

    // Read mux: current value of the addressed CSR, unimplemented addresses read zero
    always_comb begin
        csr_rdata_s = ZERO_WORD;
        case (csr_addr_i)
            ADDR_MSTATUS:   csr_rdata_s = {19'h0, 2'b11, 3'b000, mstatus_mpie_q, 3'b000, mstatus_mie_q, 3'b000};
            ADDR_MISA:      csr_rdata_s = MISA_VALUE;
            ADDR_MIE:       csr_rdata_s = mie_q;
            ADDR_MTVEC:     csr_rdata_s = mtvec_q;
            ADDR_MSCRATCH:  csr_rdata_s = mscratch_q;
            ADDR_MEPC:      csr_rdata_s = mepc_q;
            ADDR_MCAUSE:    csr_rdata_s = mcause_q;
            ADDR_MTVAL:     csr_rdata_s = mtval_q;
            ADDR_MIP:       csr_rdata_s = ZERO_WORD;
            ADDR_MCYCLE,
            ADDR_CYCLE:     csr_rdata_s = mcycle_q[31:0];
            ADDR_MCYCLEH,
            ADDR_CYCLEH:    csr_rdata_s = mcycle_q[63:32];
            ADDR_MINSTRET:  csr_rdata_s = minstret_q[31:0];
            ADDR_MINSTRETH: csr_rdata_s = minstret_q[63:32];
            default:        csr_rdata_s = ZERO_WORD;
        endcase
    end

    assign val_csr_o = re_csr_i ? csr_rdata_s : ZERO_WORD;

    // Read-modify-write value from the funct3 operation; 000 and 100 never write
    always_comb begin
        wdata_s    = csr_rdata_s;
        op_valid_s = 1'b0;
        case (csr_opcode_i)
            3'b001, 3'b101: begin
                wdata_s    = val_csr_i;
                op_valid_s = 1'b1;
            end
            3'b010, 3'b110: begin
                wdata_s    = csr_rdata_s | val_csr_i;
                op_valid_s = 1'b1;
            end
            3'b011, 3'b111: begin
                wdata_s    = csr_rdata_s & ~val_csr_i;
                op_valid_s = 1'b1;
            end
            default: begin
                wdata_s    = csr_rdata_s;
                op_valid_s = 1'b0;
            end
        endcase
    end

    assign wr_en_s = we_csr_i & op_valid_s;

    // Write-target decode; read-only and unknown addresses select nothing
    always_comb begin
        sel_mstatus_s   = 1'b0;
        sel_mie_s       = 1'b0;
        sel_mtvec_s     = 1'b0;
        sel_mscratch_s  = 1'b0;
        sel_mepc_s      = 1'b0;
        sel_mcause_s    = 1'b0;
        sel_mtval_s     = 1'b0;
        sel_mcycle_s    = 1'b0;
        sel_mcycleh_s   = 1'b0;
        sel_minstret_s  = 1'b0;
        sel_minstreth_s = 1'b0;
        case (csr_addr_i)
            ADDR_MSTATUS:   sel_mstatus_s   = wr_en_s;
            ADDR_MIE:       sel_mie_s       = wr_en_s;
            ADDR_MTVEC:     sel_mtvec_s     = wr_en_s;
            ADDR_MSCRATCH:  sel_mscratch_s  = wr_en_s;
            ADDR_MEPC:      sel_mepc_s      = wr_en_s;
            ADDR_MCAUSE:    sel_mcause_s    = wr_en_s;
            ADDR_MTVAL:     sel_mtval_s     = wr_en_s;
            ADDR_MCYCLE:    sel_mcycle_s    = wr_en_s;
            ADDR_MCYCLEH:   sel_mcycleh_s   = wr_en_s;
            ADDR_MINSTRET:  sel_minstret_s  = wr_en_s;
            ADDR_MINSTRETH: sel_minstreth_s = wr_en_s;
            default:        sel_mstatus_s   = 1'b0;
        endcase
    end

    assign mcycle_inc_s = mcycle_q + 64'd1;

    // Next-state values; a counter-word write replaces that word's increment and suppresses carry into the high word
    always_comb begin
        mstatus_mie_d  = sel_mstatus_s  ? wdata_s[3]             : mstatus_mie_q;
        mstatus_mpie_d = sel_mstatus_s  ? wdata_s[7]             : mstatus_mpie_q;
        mie_d          = sel_mie_s      ? (wdata_s & MIE_MASK)   : mie_q;
        mtvec_d        = sel_mtvec_s    ? (wdata_s & 32'hFFFF_FFFD) : mtvec_q;
        mscratch_d     = sel_mscratch_s ? wdata_s                : mscratch_q;
        mepc_d         = sel_mepc_s     ? (wdata_s & 32'hFFFF_FFFC) : mepc_q;
        mcause_d       = sel_mcause_s   ? wdata_s                : mcause_q;
        mtval_d        = sel_mtval_s    ? wdata_s                : mtval_q;

        mcycle_d[31:0]  = sel_mcycle_s  ? wdata_s : mcycle_inc_s[31:0];
        mcycle_d[63:32] = sel_mcycleh_s ? wdata_s :
                          (sel_mcycle_s ? mcycle_q[63:32] : mcycle_inc_s[63:32]);

        minstret_d[31:0]  = sel_minstret_s  ? wdata_s : minstret_q[31:0];
        minstret_d[63:32] = sel_minstreth_s ? wdata_s : minstret_q[63:32];
    end

    // State registers with asynchronous reset to architectural reset values
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 32'h0000_0000;
            mtvec_q        <= 32'h0000_0000;
            mscratch_q     <= 32'h0000_0000;
            mepc_q         <= 32'h0000_0000;
            mcause_q       <= 32'h0000_0000;
            mtval_q        <= 32'h0000_0000;
            mcycle_q       <= 64'h0;
            minstret_q     <= 64'h0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            mcycle_q       <= mcycle_d;
            minstret_q     <= minstret_d;
        end
    end

endmodule

// File: tb/tb_rv32im_csr_unit.sv
// Directed-vector bench for rv32im_csr_unit with hand-computed expected values
// and a reference count of clock edges since reset release.
module tb_rv32im_csr_unit;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_RW   = 3'b001;
    localparam logic [2:0] OP_RS   = 3'b010;
    localparam logic [2:0] OP_RC   = 3'b011;
    localparam logic [2:0] OP_R4   = 3'b100;
    localparam logic [2:0] OP_RWI  = 3'b101;
    localparam logic [2:0] OP_RSI  = 3'b110;
    localparam logic [2:0] OP_RCI  = 3'b111;

    logic        clk;
    logic        rst_n;
    logic [11:0] addr;
    logic [31:0] din;
    logic        we;
    logic        re;
    logic [2:0]  op;
    logic [31:0] dout;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp_cyc;

    rv32im_csr_unit dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .csr_addr_i   (addr),
        .val_csr_i    (din),
        .we_csr_i     (we),
        .re_csr_i     (re),
        .csr_opcode_i (op),
        .val_csr_o    (dout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference cycle count: edges seen since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_cyc <= 64'h0;
        else        exp_cyc <= exp_cyc + 64'd1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [11:0] a, input logic [2:0] o, input logic [31:0] v,
                         input logic w, input logic r);
        addr = a;
        op   = o;
        din  = v;
        we   = w;
        re   = r;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(12'h000, OP_NONE, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        drive(12'h300, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("rst_mstatus", dout, 32'h0000_1800);
        drive(12'hB00, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("rst_mcycle", dout, 32'h0);
        drive(12'h301, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("rst_misa", dout, 32'h4000_1100);
        drive(12'h300, OP_RW, 32'h0, 1'b0, 1'b0); #1 check_val("re_off", dout, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(12'hB00, OP_RW, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            tick; #1 check_val("mcycle_count", dout, 32'(i));
        end

        drive(12'h300, OP_RW, 32'hF000_0000, 1'b1, 1'b1); #1 check_val("mstatus_old", dout, 32'h0000_1800);
        tick;
        drive(12'h300, OP_RW, 32'h0000_0088, 1'b1, 1'b1); #1 check_val("mstatus_same_cyc", dout, 32'h0000_1800);
        tick;
        drive(12'h300, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mstatus_new", dout, 32'h0000_1888);
        drive(12'h300, OP_RCI, 32'h0000_0008, 1'b1, 1'b1);
        tick;
        drive(12'h300, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mstatus_rci", dout, 32'h0000_1880);

        drive(12'h340, OP_RW, 32'h0000_F0F0, 1'b1, 1'b1);
        tick;
        drive(12'h340, OP_RS, 32'h0F00_0000, 1'b1, 1'b1); #1 check_val("mscratch_rw", dout, 32'h0000_F0F0);
        tick;
        drive(12'h340, OP_RC, 32'h0000_00F0, 1'b1, 1'b1); #1 check_val("mscratch_rs", dout, 32'h0F00_F0F0);
        tick;
        drive(12'h340, OP_NONE, 32'hFFFF_FFFF, 1'b1, 1'b1); #1 check_val("mscratch_rc", dout, 32'h0F00_F000);
        tick;
        drive(12'h340, OP_R4, 32'hFFFF_FFFF, 1'b1, 1'b1); #1 check_val("mscratch_op000", dout, 32'h0F00_F000);
        tick;
        drive(12'h340, OP_RCI, 32'h0F00_0000, 1'b1, 1'b1); #1 check_val("mscratch_op100", dout, 32'h0F00_F000);
        tick;
        drive(12'h340, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mscratch_rci", dout, 32'h0000_F000);

        drive(12'h304, OP_RWI, 32'hFFFF_FFFF, 1'b1, 1'b1); tick;
        drive(12'h304, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mie_mask", dout, 32'h0000_0888);
        drive(12'h305, OP_RW, 32'hFFFF_FFFF, 1'b1, 1'b1); tick;
        drive(12'h305, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mtvec_bit1", dout, 32'hFFFF_FFFD);
        drive(12'h341, OP_RW, 32'hFFFF_FFFF, 1'b1, 1'b1); tick;
        drive(12'h341, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mepc_align", dout, 32'hFFFF_FFFC);
        drive(12'h343, OP_RSI, 32'h0000_001F, 1'b1, 1'b1); tick;
        drive(12'h343, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mtval_rsi", dout, 32'h0000_001F);

        drive(12'h301, OP_RW, 32'hFFFF_FFFF, 1'b1, 1'b1); tick;
        drive(12'h301, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("misa_ro", dout, 32'h4000_1100);
        drive(12'h344, OP_RW, 32'hFFFF_FFFF, 1'b1, 1'b1); tick;
        drive(12'h344, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mip_ro", dout, 32'h0);
        drive(12'h7C0, OP_RW, 32'hFFFF_FFFF, 1'b1, 1'b1); tick;
        drive(12'h7C0, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("unimpl", dout, 32'h0);
        drive(12'hF14, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mhartid", dout, 32'h0);

        drive(12'hC00, OP_RW, 32'h0, 1'b1, 1'b1); tick;
        drive(12'hC00, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("cycle_ro", dout, exp_cyc[31:0]);
        drive(12'hB00, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mcycle_ref", dout, exp_cyc[31:0]);
        drive(12'hC80, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("cycleh_ref", dout, exp_cyc[63:32]);

        drive(12'hB02, OP_RW, 32'h1234_5678, 1'b1, 1'b1); tick;
        drive(12'hB02, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("minstret_wr", dout, 32'h1234_5678);
        tick; #1 check_val("minstret_hold", dout, 32'h1234_5678);
        drive(12'hB82, OP_RW, 32'h0000_ABCD, 1'b1, 1'b1); tick;
        drive(12'hB82, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("minstreth_wr", dout, 32'h0000_ABCD);

        drive(12'hB80, OP_RW, 32'h0000_0005, 1'b1, 1'b1); tick;
        drive(12'hB00, OP_RW, 32'hFFFF_FFFF, 1'b1, 1'b1); tick;
        drive(12'hB00, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mcycle_wr", dout, 32'hFFFF_FFFF);
        drive(12'hB80, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mcycleh_wr", dout, 32'h0000_0005);
        tick;
        drive(12'hB00, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mcycle_wrap", dout, 32'h0);
        drive(12'hB80, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mcycleh_carry", dout, 32'h0000_0006);

        drive(12'hB00, OP_RW, 32'hFFFF_FFFF, 1'b1, 1'b1); tick;
        drive(12'hB00, OP_RW, 32'h0000_0010, 1'b1, 1'b1); tick;
        drive(12'hB00, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mcycle_wr_carry", dout, 32'h0000_0010);
        drive(12'hB80, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("mcycleh_no_carry", dout, 32'h0000_0006);

        drive(12'hB00, OP_RW, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_val("async_mcycle", dout, 32'h0);
        drive(12'h300, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("async_mstatus", dout, 32'h0000_1800);
        drive(12'h340, OP_RW, 32'h0, 1'b0, 1'b1); #1 check_val("async_mscratch", dout, 32'h0);
        drive(12'h301, OP_RW, 32'h0, 1'b0, 1'b0); #1 check_val("async_re_off", dout, 32'h0);
        drive(12'hB00, OP_RW, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1 check_val("rst_hold", dout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick; #1 check_val("rst_release", dout, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
